// File: rtl/perfctr_bank_pkg.sv
// Shared register map, CTRL/CFG bit positions and lane-merge helper for the
// performance-counter bank.
package perfctr_bank_pkg;

  localparam logic [5:0] OFS_CTRL = 6'h00;
  localparam logic [5:0] OFS_OVF  = 6'h01;
  localparam logic [5:0] OFS_IEN  = 6'h02;
  localparam logic [5:0] OFS_ID   = 6'h03;
  localparam logic [5:0] OFS_CFG  = 6'h10;
  localparam logic [5:0] OFS_CNT  = 6'h20;
  localparam logic [5:0] OFS_SNAP = 6'h30;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_FRZ  = 1;
  localparam int CTRL_SNAP = 2;
  localparam int CTRL_CLR  = 3;
  localparam int CFG_EN    = 8;

  // wen[0] covers bits 15:0, wen[1] covers bits 31:16
  function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                             input logic [31:0] wdat,
                                             input logic [1:0]  wen);
    logic [31:0] m;
    m = {{16{wen[1]}}, {16{wen[0]}}};
    return (old & ~m) | (wdat & m);
  endfunction

endpackage

// File: rtl/perfctr_cell.sv
// One counter of the bank: event select/enable, write/clear priority,
// wrap detection and snapshot register.
module perfctr_cell
  import perfctr_bank_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int N_EVT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             count_en,
  input  logic             clear_all,
  input  logic             snap,
  input  logic [N_EVT-1:0] evt,
  input  logic             cfg_we,
  input  logic             cnt_we,
  input  logic [1:0]       wen,
  input  logic [31:0]      wdata,
  output logic [31:0]      cfg_rd,
  output logic [31:0]      cnt_rd,
  output logic [31:0]      snap_rd,
  output logic             wrap
);

  logic [4:0]       sel;
  logic             en;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] snap_q;
  logic [31:0]      evt_ext;
  logic [31:0]      cnt_new;
  logic             hit;

  // Zero-extending the event vector makes any select >= N_EVT pick a 0 bit
  assign evt_ext = 32'(evt);
  assign hit     = count_en && en && evt_ext[sel];
  assign wrap    = hit && !init && !clear_all && !cnt_we && (&cnt);

  assign cfg_rd  = {23'b0, en, 3'b0, sel};
  assign cnt_rd  = 32'(cnt);
  assign snap_rd = 32'(snap_q);
  assign cnt_new = lane_merge(cnt_rd, wdata, wen);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel    <= '0;
      en     <= 1'b0;
      cnt    <= '0;
      snap_q <= '0;
    end else begin
      if (cfg_we && wen[0]) begin
        sel <= wdata[4:0];
        en  <= wdata[CFG_EN];
      end
      if (init) begin
        cnt    <= '0;
        snap_q <= '0;
      end else begin
        if (snap) snap_q <= cnt;
        if (clear_all)   cnt <= '0;
        else if (cnt_we) cnt <= cnt_new[CNT_W-1:0];
        else if (hit)    cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/perfctr_bank.sv
// Parametrised performance-counter bank with mgmt-bus register window,
// global freeze/snapshot/clear and maskable sticky-overflow interrupt.
module perfctr_bank
  import perfctr_bank_pkg::*;
#(
  parameter int          N_CNT = 8,
  parameter int          N_EVT = 16,
  parameter int          CNT_W = 32,
  parameter logic [31:0] BASE  = 32'h0000_0100,
  parameter logic [31:0] MASK  = 32'hFFFF_FF00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [N_EVT-1:0] evt,
  output logic             irq,
  input  logic             mgmt_req,
  input  logic [31:0]      mgmt_adr,
  output logic             mgmt_ack,
  input  logic             mgmt_rwn,
  input  logic [1:0]       mgmt_wen,
  input  logic [31:0]      mgmt_txd,
  output logic             mgmt_rxe,
  output logic [31:0]      mgmt_rxd
);

  logic [31:2]      adr_q;
  logic [31:0]      txd_q;
  logic             rwn_q;
  logic [1:0]       wen_q;
  logic             busy, issue, fin;
  logic             ctrl_en, ctrl_frz;
  logic [N_CNT-1:0] ovf, ien, wrap, ovf_clr;
  logic [5:0]       ofs;
  logic [3:0]       idx;
  logic             in_win, wr_stb, wr_ctrl, snap_p, clr_p;
  logic [31:0]      rdata;
  logic [31:0]      cfg_rd  [16];
  logic [31:0]      cnt_rd  [16];
  logic [31:0]      snap_rd [16];

  assign ofs     = adr_q[7:2];
  assign idx     = ofs[3:0];
  assign in_win  = ((({adr_q, 2'b00}) ^ BASE) & MASK) == 32'h0;
  assign wr_stb  = issue && in_win && !rwn_q;
  assign wr_ctrl = wr_stb && (ofs == OFS_CTRL) && wen_q[0];
  assign snap_p  = wr_ctrl && txd_q[CTRL_SNAP];
  assign clr_p   = wr_ctrl && txd_q[CTRL_CLR];
  assign ovf_clr = (wr_stb && (ofs == OFS_OVF) && wen_q[0]) ? txd_q[N_CNT-1:0] : '0;

  // Slots beyond N_CNT read as zero and ignore writes
  for (genvar i = 0; i < 16; i++) begin : g_cell
    if (i < N_CNT) begin : g_on
      perfctr_cell #(.CNT_W(CNT_W), .N_EVT(N_EVT)) u_cell (
        .clk       (clk),
        .rst       (rst),
        .init      (init),
        .count_en  (ctrl_en && !ctrl_frz),
        .clear_all (clr_p),
        .snap      (snap_p),
        .evt       (evt),
        .cfg_we    (wr_stb && (ofs[5:4] == OFS_CFG[5:4]) && (idx == 4'(i))),
        .cnt_we    (wr_stb && (ofs[5:4] == OFS_CNT[5:4]) && (idx == 4'(i))),
        .wen       (wen_q),
        .wdata     (txd_q),
        .cfg_rd    (cfg_rd[i]),
        .cnt_rd    (cnt_rd[i]),
        .snap_rd   (snap_rd[i]),
        .wrap      (wrap[i])
      );
    end else begin : g_off
      assign cfg_rd[i]  = '0;
      assign cnt_rd[i]  = '0;
      assign snap_rd[i] = '0;
    end
  end

  always_comb begin
    rdata = '0;
    if (ofs == OFS_CTRL)                  rdata = {30'b0, ctrl_frz, ctrl_en};
    else if (ofs == OFS_OVF)              rdata = 32'(ovf);
    else if (ofs == OFS_IEN)              rdata = 32'(ien);
    else if (ofs == OFS_ID)               rdata = {8'h00, 8'(CNT_W), 8'(N_EVT), 8'(N_CNT)};
    else if (ofs[5:4] == OFS_CFG[5:4])    rdata = cfg_rd[idx];
    else if (ofs[5:4] == OFS_CNT[5:4])    rdata = cnt_rd[idx];
    else if (ofs[5:4] == OFS_SNAP[5:4])   rdata = snap_rd[idx];
  end

  // Bus handshake, global registers and interrupt; read data is taken from
  // pre-edge state so a same-cycle update is not visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_q    <= '0;
      txd_q    <= '0;
      rwn_q    <= 1'b0;
      wen_q    <= '0;
      busy     <= 1'b0;
      issue    <= 1'b0;
      fin      <= 1'b0;
      mgmt_ack <= 1'b0;
      mgmt_rxe <= 1'b0;
      mgmt_rxd <= '0;
      ctrl_en  <= 1'b0;
      ctrl_frz <= 1'b0;
      ovf      <= '0;
      ien      <= '0;
      irq      <= 1'b0;
    end else begin
      adr_q    <= mgmt_adr[31:2];
      txd_q    <= mgmt_txd;
      rwn_q    <= mgmt_rwn;
      wen_q    <= mgmt_wen;
      busy     <= mgmt_req && !fin;
      issue    <= mgmt_req && !busy;
      fin      <= issue;
      mgmt_ack <= issue && in_win;
      mgmt_rxe <= issue && in_win && rwn_q;
      mgmt_rxd <= (issue && in_win && rwn_q) ? rdata : '0;
      irq      <= |(ovf & ien);
      if (wr_stb && (ofs == OFS_IEN) && wen_q[0]) ien <= txd_q[N_CNT-1:0];
      if (init) begin
        ctrl_en  <= 1'b0;
        ctrl_frz <= 1'b0;
        ovf      <= '0;
      end else begin
        if (wr_ctrl) begin
          ctrl_en  <= txd_q[CTRL_EN];
          ctrl_frz <= txd_q[CTRL_FRZ];
        end
        ovf <= (ovf & ~ovf_clr) | wrap;
      end
    end
  end

endmodule
